// File: rtl/pipelined_carry_adder_if.sv
// pipelined_carry_adder_if: valid/ready operand and result bus for the pipelined carry adder
// Operand side: in_valid, in_ready, a, b, cin, sub.
// Result side:  out_valid, out_ready, sum, cout, overflow.
// Modports: master is the producer/consumer side; slave is the adder.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract with the carry chain split into STAGES registered segments
// Ports: clk (rising edge), rst_n (async active-low), bus (slave modport: operand beat in, result beat out).
// WIDTH >= 2 and WIDTH % STAGES == 0; each stage adds WIDTH/STAGES bits. sub=1 computes a + ~b + 1.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipelined_carry_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;
    logic             vld  [STAGES];
    logic             ld   [STAGES];
    logic [WIDTH-1:0] pa   [STAGES];
    logic [WIDTH-1:0] pb   [STAGES];
    logic [WIDTH-1:0] ps   [STAGES];
    logic             pc   [STAGES];
    logic             ov;
    logic [SW:0]      seg  [STAGES];
    logic [WIDTH-1:0] ns   [STAGES];
    logic             nov;
    // Stage k input: index 0 is the operand bus, index k+1 is stage k's register.
    logic             iv   [STAGES+1];
    logic [WIDTH-1:0] ia   [STAGES+1];
    logic [WIDTH-1:0] ib   [STAGES+1];
    logic [WIDTH-1:0] isum [STAGES+1];
    logic             ic   [STAGES+1];
    // A stage can load when it is empty or its content moves on this cycle.
    always_comb begin
        ld[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) ld[k] = !vld[k] || ld[k+1];
    end
    always_comb begin
        iv[0]   = bus.in_valid;
        ia[0]   = bus.a;
        ib[0]   = bus.sub ? ~bus.b : bus.b;
        isum[0] = '0;
        ic[0]   = bus.sub ? 1'b1 : bus.cin;
        for (int k = 0; k < STAGES; k++) begin
            seg[k] = {1'b0, ia[k][k*SW +: SW]} + {1'b0, ib[k][k*SW +: SW]} + {{SW{1'b0}}, ic[k]};
            ns[k] = isum[k];
            ns[k][k*SW +: SW] = seg[k][SW-1:0];
            iv[k+1]   = vld[k];
            ia[k+1]   = pa[k];
            ib[k+1]   = pb[k];
            isum[k+1] = ps[k];
            ic[k+1]   = pc[k];
        end
        // carry into the MSB recovered as a ^ b ^ sum at that bit
        nov = ia[STAGES-1][WIDTH-1] ^ ib[STAGES-1][WIDTH-1] ^ seg[STAGES-1][SW-1] ^ seg[STAGES-1][SW];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                vld[k] <= 1'b0;
                pa[k]  <= '0;
                pb[k]  <= '0;
                ps[k]  <= '0;
                pc[k]  <= 1'b0;
            end
            ov <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld[k] <= iv[k];
                    if (iv[k]) begin
                        pa[k] <= ia[k];
                        pb[k] <= ib[k];
                        ps[k] <= ns[k];
                        pc[k] <= seg[k][SW];
                    end
                end
            end
            if (ld[STAGES-1] && iv[STAGES-1]) ov <= nov;
        end
    end
    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = ps[STAGES-1];
    assign bus.cout      = pc[STAGES-1];
    assign bus.overflow  = ov;
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed and model-checked bench for pipelined_carry_adder
module tb_pipelined_carry_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic go = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    pipelined_carry_adder_if #(.WIDTH(16)) m ();
    pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // returns {overflow, cout, sum} for a w-bit add/subtract
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [31:0] msk, be, full, low;
        logic        c0, ci, co;
        msk  = (32'd1 << w) - 32'd1;
        be   = (sub ? ~{16'h0, b} : {16'h0, b}) & msk;
        c0   = sub ? 1'b1 : cin;
        full = ({16'h0, a} & msk) + be + {31'h0, c0};
        low  = ({16'h0, a} & (msk >> 1)) + (be & (msk >> 1)) + {31'h0, c0};
        co   = full[w];
        ci   = low[w-1];
        return {ci ^ co, co, full[15:0] & msk[15:0]};
    endfunction
    task automatic one(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo, input string tag);
        int n;
        @(negedge clk);
        m.a = a; m.b = b; m.cin = cin; m.sub = sub; m.in_valid = 1'b1; m.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(m.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        m.in_valid = 1'b0;
        n = 1;
        #1;
        while (!m.out_valid && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, 32'(m.sum), 32'(es));
        check({tag, "_cout"}, 32'(m.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(m.overflow), 32'(eo));
    endtask
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int S = g == 0 ? 1 : g == 1 ? 2 : 8;
        logic done_s = 1'b0;
        pipelined_carry_adder_if #(.WIDTH(8)) bus ();
        pipelined_carry_adder #(.WIDTH(8), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
        initial begin
            logic [31:0] q[$];
            logic [31:0] e;
            int          n, sent, got;
            logic        acc;
            bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
            wait (go);
            @(negedge clk);
            bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.a = 8'h3C; bus.b = 8'h5A; bus.cin = 1'b1; bus.sub = 1'b0;
            #1 check($sformatf("s%0d_in_ready", S), 32'(bus.in_ready), 1);
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n = 1;
            #1;
            while (!bus.out_valid && n < 40) begin
                @(negedge clk);
                #1 n++;
            end
            check($sformatf("s%0d_latency", S), n, S);
            check($sformatf("s%0d_first", S), 32'({bus.overflow, bus.cout, bus.sum}), 32'h297);
            sent = 0; got = 0; acc = 1'b0;
            for (int c = 0; c < 20000 && got < 1000; c++) begin
                @(negedge clk);
                if (!bus.in_valid || acc) begin
                    bus.in_valid = sent < 1000 && $urandom_range(0, 3) != 0;
                    bus.a = 8'($urandom); bus.b = 8'($urandom);
                    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
                end
                bus.out_ready = $urandom_range(0, 3) != 0;
                #1;
                acc = bus.in_valid && bus.in_ready;
                if (acc) begin
                    q.push_back(32'(model(8, {8'h0, bus.a}, {8'h0, bus.b}, bus.cin, bus.sub)));
                    sent++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    e = q.size() > 0 ? q.pop_front() : 32'hFFFF_FFFF;
                    check($sformatf("s%0d_beat%0d", S, got), 32'({bus.overflow, bus.cout, 8'h00, bus.sum}), e);
                    got++;
                end
            end
            bus.in_valid = 1'b0;
            check($sformatf("s%0d_count", S), got, 1000);
            done_s = 1'b1;
        end
    end
    initial begin
        logic [31:0] q[$];
        logic [31:0] e;
        logic [15:0] prev;
        int          sent, got, viol, full_at, stale;
        logic        acc, stall_prev;
        m.in_valid = 1'b0; m.out_ready = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(m.out_valid), 0);
        check("rst_sum", 32'(m.sum), 0);
        check("rst_cout", 32'(m.cout), 0);
        check("rst_ovf", 32'(m.overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(m.in_ready), 1);
        one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        one(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_cin");
        one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        @(negedge clk);
        #1 check("hold_after_valid", 32'({m.out_valid, m.sum}), 32'h07FFF);
        sent = 0; got = 0; viol = 0; full_at = -1; acc = 1'b0; stall_prev = 1'b0; prev = '0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            @(negedge clk);
            if (!m.in_valid || acc) begin
                m.in_valid = sent < 8;
                m.a = 16'(sent + 1);
                m.b = 16'(16'h0100 * (sent + 1));
                m.cin = 1'b0; m.sub = 1'b0;
            end
            m.out_ready = c >= 6;
            #1;
            acc = m.in_valid && m.in_ready;
            if (m.in_valid && !m.in_ready && full_at < 0) full_at = sent;
            if (stall_prev && (!m.out_valid || m.sum !== prev)) viol++;
            stall_prev = m.out_valid && !m.out_ready;
            prev = m.sum;
            if (acc) begin
                q.push_back(32'(model(16, m.a, m.b, m.cin, m.sub)));
                sent++;
            end
            if (m.out_valid && m.out_ready) begin
                e = q.size() > 0 ? q.pop_front() : 32'hFFFF_FFFF;
                check($sformatf("bp_beat%0d", got), 32'({m.overflow, m.cout, m.sum}), e);
                got++;
            end
        end
        check("bp_full_at", full_at, 4);
        check("bp_hold", viol, 0);
        check("bp_count", got, 8);
        @(negedge clk);
        m.in_valid = 1'b1; m.out_ready = 1'b0; m.a = 16'h1234; m.b = 16'h1111; m.cin = 1'b0; m.sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        m.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_pre_valid", 32'(m.out_valid), 1);
        check("mid_pre_sum", 32'(m.sum), 32'h2345);
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(m.out_valid), 0);
        check("mid_sum", 32'(m.sum), 0);
        check("mid_cout", 32'(m.cout), 0);
        check("mid_ovf", 32'(m.overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m.out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            #1 if (m.out_valid) stale++;
        end
        check("mid_stale", stale, 0);
        go = 1'b1;
        for (int c = 0; c < 30000 && !(sw[0].done_s && sw[1].done_s && sw[2].done_s); c++) @(negedge clk);
        check("sweep_done", 32'({sw[0].done_s, sw[1].done_s, sw[2].done_s}), 32'h7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
